// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles an MSB-first serial word and strobes it onto a parallel register bus
module serial_word_loader #(
  parameter int WIDTH = 16,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             abort
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             last;
  // state, shift register, bit counter, output word and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  // next state; start beats ser_valid in SHIFT, and data_out only moves on word completion
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    last    = cnt_q == CW'(WIDTH - 1);
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        shift_d = '0;
        cnt_d   = '0;
      end
      SHIFT: if (start) begin
        shift_d = '0;
        cnt_d   = '0;
        abort_d = 1'b1;
      end else if (ser_valid) begin
        shift_d = {shift_q[WIDTH-2:0], ser_in};
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? LOAD : SHIFT;
        data_d  = last ? {shift_q[WIDTH-2:0], ser_in} : data_q;
      end
      LOAD: begin
        state_d = start ? SHIFT : IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy     = state_q != IDLE;
  assign load     = state_q == LOAD;
  assign bit_cnt  = cnt_q;
  assign data_out = data_q;
  assign abort    = abort_q;
endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: randomized scenario bench for serial_word_loader
module tb_serial_word_loader;
  localparam int W = 16;
  logic clk = 1'b0, rst, start, ser_in, ser_valid;
  logic busy, load, abort;
  logic [3:0] bit_cnt;
  logic [W-1:0] data_out;
  int n_chk = 0, n_fail = 0, cyc = 0, loads = 0, aborts = 0;
  logic [W-1:0] exp_last = '0;
  always #5 clk = ~clk;
  serial_word_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
    .busy(busy), .bit_cnt(bit_cnt), .data_out(data_out), .load(load), .abort(abort)
  );
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (load) loads++;
    if (abort) aborts++;
  endtask
  task automatic idle(input int n);
    ser_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_in = b;
    step();
    ser_valid = 1'b0;
    ser_in = 1'($urandom);
  endtask
  task automatic send_word(input logic [W-1:0] w, input int maxgap);
    for (int k = 0; k < W; k++) begin
      if (maxgap > 0) idle($urandom_range(1, maxgap));
      send_bit(w[W-1-k]);
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    step(); step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    n_chk++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", data_out); end
    n_chk++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%b exp=0", load); end
    n_chk++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got=%b exp=0", abort); end
    rst = 1'b0;
    ser_valid = 1'b1;
    step();
    ser_valid = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy got=%b exp=0", busy); end
  endtask
  task automatic test_basic(input logic [W-1:0] w);
    int l0;
    l0 = loads;
    do_start();
    n_chk++; if (busy !== 1'b1 || bit_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_start got busy=%b cnt=%0d exp busy=1 cnt=0", busy, bit_cnt); end
    send_word(w, 0);
    n_chk++; if (load !== 1'b1) begin n_fail++; $display("FAIL basic_load got=%b exp=1", load); end
    n_chk++; if (data_out !== w) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", data_out, w); end
    n_chk++; if (loads - l0 !== 1) begin n_fail++; $display("FAIL basic_load_count got=%0d exp=1", loads - l0); end
    step();
    n_chk++; if (load !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after got load=%b busy=%b exp 0 0", load, busy); end
    exp_last = w;
  endtask
  task automatic test_stall(input logic [W-1:0] w);
    int l0;
    l0 = loads;
    do_start();
    for (int k = 0; k < W; k++) begin
      idle($urandom_range(1, 5));
      n_chk++; if (bit_cnt !== 4'(k)) begin n_fail++; $display("FAIL stall_bit_cnt got=%0d exp=%0d", bit_cnt, k); end
      n_chk++; if (data_out !== exp_last) begin n_fail++; $display("FAIL stall_hold_data got=%h exp=%h", data_out, exp_last); end
      send_bit(w[W-1-k]);
    end
    n_chk++; if (load !== 1'b1 || data_out !== w) begin n_fail++; $display("FAIL stall_load got load=%b data=%h exp load=1 data=%h", load, data_out, w); end
    step();
    n_chk++; if (loads - l0 !== 1) begin n_fail++; $display("FAIL stall_load_count got=%0d exp=1", loads - l0); end
    exp_last = w;
  endtask
  task automatic test_restart(input logic [W-1:0] w);
    int l0, a0;
    l0 = loads;
    a0 = aborts;
    do_start();
    for (int k = 0; k < 7; k++) send_bit(1'($urandom));
    n_chk++; if (data_out !== exp_last) begin n_fail++; $display("FAIL restart_prev_data got=%h exp=%h", data_out, exp_last); end
    do_start();
    n_chk++; if (abort !== 1'b1 || bit_cnt !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_abort got abort=%b cnt=%0d busy=%b exp 1 0 1", abort, bit_cnt, busy); end
    n_chk++; if (data_out !== exp_last) begin n_fail++; $display("FAIL restart_hold_data got=%h exp=%h", data_out, exp_last); end
    send_word(w, $urandom_range(0, 3));
    n_chk++; if (load !== 1'b1 || data_out !== w) begin n_fail++; $display("FAIL restart_load got load=%b data=%h exp load=1 data=%h", load, data_out, w); end
    step();
    n_chk++; if (aborts - a0 !== 1 || loads - l0 !== 1) begin n_fail++; $display("FAIL restart_counts got aborts=%0d loads=%0d exp 1 1", aborts - a0, loads - l0); end
    exp_last = w;
  endtask
  task automatic test_back_to_back();
    int c0, low;
    low = 0;
    do_start();
    send_word(16'hFFFF, 0);
    n_chk++; if (load !== 1'b1 || data_out !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_first got load=%b data=%h exp load=1 data=ffff", load, data_out); end
    c0 = cyc;
    do_start();
    if (busy !== 1'b1) low++;
    for (int k = 0; k < W; k++) begin
      send_bit(k == W - 1);
      if (busy !== 1'b1) low++;
    end
    n_chk++; if (load !== 1'b1 || data_out !== 16'h0001) begin n_fail++; $display("FAIL b2b_second got load=%b data=%h exp load=1 data=0001", load, data_out); end
    n_chk++; if (cyc - c0 !== W + 1) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - c0, W + 1); end
    n_chk++; if (low !== 0) begin n_fail++; $display("FAIL b2b_busy got=%0d low cycles exp=0", low); end
    step();
    exp_last = 16'h0001;
  endtask
  task automatic test_reset_mid();
    int l0, a0;
    logic [W-1:0] w;
    w = 16'hBEEF;
    do_start();
    for (int k = 0; k < 10; k++) send_bit(w[W-1-k]);
    l0 = loads;
    a0 = aborts;
    rst = 1'b1; start = 1'b1; ser_valid = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; ser_valid = 1'b0;
    n_chk++; if (busy !== 1'b0 || bit_cnt !== 4'd0 || data_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_state got busy=%b cnt=%0d data=%h exp 0 0 0000", busy, bit_cnt, data_out); end
    idle(3);
    n_chk++; if (loads !== l0 || aborts !== a0) begin n_fail++; $display("FAIL rstmid_pulses got loads=%0d aborts=%0d exp 0 0", loads - l0, aborts - a0); end
    do_start();
    send_word(16'h5A5A, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (load !== 1'b0 || data_out !== 16'h0) begin n_fail++; $display("FAIL rst_in_load got load=%b data=%h exp 0 0000", load, data_out); end
    exp_last = '0;
    test_basic(16'($urandom));
  endtask
  task automatic test_collision(input logic [W-1:0] w);
    do_start();
    for (int k = 0; k < 5; k++) send_bit(1'($urandom));
    start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    step();
    start = 1'b0; ser_valid = 1'b0;
    n_chk++; if (bit_cnt !== 4'd0 || abort !== 1'b1) begin n_fail++; $display("FAIL collision_drop got cnt=%0d abort=%b exp 0 1", bit_cnt, abort); end
    send_word(w, 2);
    n_chk++; if (load !== 1'b1 || data_out !== w) begin n_fail++; $display("FAIL collision_word got load=%b data=%h exp load=1 data=%h", load, data_out, w); end
    step();
    exp_last = w;
  endtask
  initial begin
    test_reset();
    test_basic(16'hA5C3);
    test_stall(16'hA5C3);
    test_restart(16'h1234);
    test_back_to_back();
    test_reset_mid();
    test_collision(16'($urandom));
    for (int r = 0; r < 8; r++) begin
      test_stall(16'($urandom));
      test_restart(16'($urandom));
      test_collision(16'($urandom));
      test_basic(16'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
